// File: rtl/instruction_fetch_if.sv
// Instruction memory request/ack bus between the fetch stage and imem.
interface instruction_fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch stage: IDLE issues, WAIT collects, HOLD presents
// the buffered word to decode; redirects restart the stream at a word-aligned target.
module instruction_fetch #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                phase_fetch,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    instruction_fetch_if.master imem,
    output logic [31:0]         inst,
    output logic [XLEN-1:0]     curr_pc_fd,
    output logic [XLEN-1:0]     next_pc_fd,
    output logic                inst_misaligned,
    output logic                stall_fetch
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t          state, state_nxt;
    logic            flush, flush_nxt;
    logic            issue, capture, deliver, done;
    logic            req_q;
    logic [XLEN-1:0] pc, req_addr;
    logic [31:0]     buffer;
    logic            mis_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        flush_nxt = flush;
        issue     = 1'b0;
        capture   = 1'b0;
        deliver   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect_valid) begin
                    state_nxt = WAIT;
                    issue     = 1'b1;
                end
            end
            WAIT: begin
                if (imem.imem_ack) begin
                    done      = 1'b1;
                    flush_nxt = 1'b0;
                    if (flush || redirect_valid) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = HOLD;
                        capture   = 1'b1;
                    end
                end else if (redirect_valid) begin
                    flush_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_nxt = IDLE;
                end else if (phase_fetch) begin
                    state_nxt = IDLE;
                    deliver   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush           <= 1'b0;
            req_q           <= 1'b0;
            req_addr        <= RESET_VECTOR;
            pc              <= RESET_VECTOR;
            buffer          <= NOP;
            mis_pend        <= 1'b0;
            inst            <= NOP;
            curr_pc_fd      <= '0;
            next_pc_fd      <= '0;
            inst_misaligned <= 1'b0;
        end else begin
            flush <= flush_nxt;
            if (issue) begin
                req_q    <= 1'b1;
                req_addr <= pc;
            end else if (done) begin
                req_q <= 1'b0;
            end
            if (capture) buffer <= imem.imem_rdata;
            if (redirect_valid) begin
                pc       <= {redirect_pc[XLEN-1:2], 2'b00};
                mis_pend <= |redirect_pc[1:0];
            end else if (deliver) begin
                pc <= pc + XLEN'(4);
            end
            if (deliver) begin
                inst            <= buffer;
                curr_pc_fd      <= pc;
                next_pc_fd      <= pc + XLEN'(4);
                inst_misaligned <= mis_pend;
            end
        end
    end

    // A flushed access keeps presenting its original address until the ack arrives,
    // even though pc already points at the redirect target.
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = flush ? req_addr : pc;
    assign stall_fetch    = (state != HOLD);
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed scenarios for the fetch stage plus a randomized run against a transaction-level model.
module tb_instruction_fetch;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        phase_fetch = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] inst, curr_pc_fd, next_pc_fd;
    logic        inst_misaligned, stall_fetch;
    int          n_cmp = 0, n_fail = 0;

    instruction_fetch_if #(.XLEN(32)) bus();

    instruction_fetch #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .phase_fetch(phase_fetch),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .imem(bus),
        .inst(inst), .curr_pc_fd(curr_pc_fd), .next_pc_fd(next_pc_fd),
        .inst_misaligned(inst_misaligned), .stall_fetch(stall_fetch)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        tick(); tick();
        n_cmp++; if ({inst, curr_pc_fd, next_pc_fd} !== {32'h13, 32'h0, 32'h0}) begin
            n_fail++; $display("FAIL reset_outs got %h/%h/%h exp 13/0/0", inst, curr_pc_fd, next_pc_fd); end
        n_cmp++; if ({bus.imem_req, stall_fetch, inst_misaligned, bus.imem_addr} !== {3'b010, 32'h0}) begin
            n_fail++; $display("FAIL reset_ctrl got req=%b stall=%b mis=%b addr=%h", bus.imem_req, stall_fetch, inst_misaligned, bus.imem_addr); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_fetch();
        tick();
        n_cmp++; if ({bus.imem_req, bus.imem_addr, stall_fetch} !== {1'b1, 32'h0, 1'b1}) begin
            n_fail++; $display("FAIL basic_issue got req=%b addr=%h stall=%b", bus.imem_req, bus.imem_addr, stall_fetch); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678; phase_fetch = 1'b1;
        tick();
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'hFFFF_0000;
        n_cmp++; if ({bus.imem_req, stall_fetch, inst} !== {2'b00, 32'h13}) begin
            n_fail++; $display("FAIL basic_hold got req=%b stall=%b inst=%h", bus.imem_req, stall_fetch, inst); end
        tick();
        n_cmp++; if ({inst, curr_pc_fd, next_pc_fd} !== {32'h1234_5678, 32'h0, 32'h4}) begin
            n_fail++; $display("FAIL basic_deliver got %h/%h/%h exp 12345678/0/4", inst, curr_pc_fd, next_pc_fd); end
        n_cmp++; if ({bus.imem_addr, stall_fetch, inst_misaligned} !== {32'h4, 2'b10}) begin
            n_fail++; $display("FAIL basic_pc got addr=%h stall=%b mis=%b", bus.imem_addr, stall_fetch, inst_misaligned); end
        phase_fetch = 1'b0;
    endtask

    task automatic test_ack_delay();
        tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({bus.imem_req, bus.imem_addr, stall_fetch} !== {1'b1, 32'h4, 1'b1}) begin
                n_fail++; $display("FAIL delay_stable[%0d] got req=%b addr=%h stall=%b", i, bus.imem_req, bus.imem_addr, stall_fetch); end
            tick();
        end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hCAFE_0001;
        tick();
        // stray ack while holding must not overwrite the buffered word
        bus.imem_rdata = 32'hDEAD_DEAD;
        tick();
        n_cmp++; if ({stall_fetch, bus.imem_req} !== 2'b00) begin
            n_fail++; $display("FAIL delay_hold got stall=%b req=%b", stall_fetch, bus.imem_req); end
        bus.imem_ack = 1'b0; phase_fetch = 1'b1;
        tick();
        phase_fetch = 1'b0;
        n_cmp++; if ({inst, curr_pc_fd, next_pc_fd} !== {32'hCAFE_0001, 32'h4, 32'h8}) begin
            n_fail++; $display("FAIL delay_deliver got %h/%h/%h exp cafe0001/4/8", inst, curr_pc_fd, next_pc_fd); end
    endtask

    task automatic test_redirect_wait();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if ({bus.imem_req, bus.imem_addr, stall_fetch} !== {1'b1, 32'h8, 1'b1}) begin
            n_fail++; $display("FAIL rwait_held got req=%b addr=%h stall=%b", bus.imem_req, bus.imem_addr, stall_fetch); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0; phase_fetch = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        n_cmp++; if ({bus.imem_req, stall_fetch, bus.imem_addr} !== {2'b01, 32'h100}) begin
            n_fail++; $display("FAIL rwait_drop got req=%b stall=%b addr=%h", bus.imem_req, stall_fetch, bus.imem_addr); end
        n_cmp++; if ({inst, curr_pc_fd} !== {32'hCAFE_0001, 32'h4}) begin
            n_fail++; $display("FAIL rwait_outs got inst=%h curr=%h", inst, curr_pc_fd); end
        tick();
        n_cmp++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h100}) begin
            n_fail++; $display("FAIL rwait_reissue got req=%b addr=%h", bus.imem_req, bus.imem_addr); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0D03;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        phase_fetch = 1'b0;
        n_cmp++; if ({inst, curr_pc_fd, next_pc_fd} !== {32'h0000_0D03, 32'h100, 32'h104}) begin
            n_fail++; $display("FAIL rwait_deliver got %h/%h/%h", inst, curr_pc_fd, next_pc_fd); end
    endtask

    task automatic test_redirect_hold();
        tick();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0D04;
        tick();
        bus.imem_ack = 1'b0; phase_fetch = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0; phase_fetch = 1'b0;
        n_cmp++; if ({inst, curr_pc_fd, next_pc_fd, stall_fetch} !== {32'h0000_0D03, 32'h100, 32'h104, 1'b1}) begin
            n_fail++; $display("FAIL rhold_outs got %h/%h/%h stall=%b", inst, curr_pc_fd, next_pc_fd, stall_fetch); end
        tick();
        n_cmp++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h200}) begin
            n_fail++; $display("FAIL rhold_reissue got req=%b addr=%h", bus.imem_req, bus.imem_addr); end
        // redirect coinciding with the ack: data dropped, restart at 0x300
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD1_BAD1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        bus.imem_ack = 1'b0; redirect_valid = 1'b0;
        n_cmp++; if ({bus.imem_req, stall_fetch, bus.imem_addr} !== {2'b01, 32'h300}) begin
            n_fail++; $display("FAIL rack_drop got req=%b stall=%b addr=%h", bus.imem_req, stall_fetch, bus.imem_addr); end
        tick();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0D06;
        tick();
        bus.imem_ack = 1'b0; phase_fetch = 1'b1;
        tick();
        phase_fetch = 1'b0;
        n_cmp++; if ({inst, curr_pc_fd} !== {32'h0000_0D06, 32'h300}) begin
            n_fail++; $display("FAIL rack_deliver got inst=%h curr=%h", inst, curr_pc_fd); end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if ({bus.imem_req, bus.imem_addr, inst_misaligned} !== {1'b0, 32'h100, 1'b0}) begin
            n_fail++; $display("FAIL mis_idle got req=%b addr=%h mis=%b", bus.imem_req, bus.imem_addr, inst_misaligned); end
        tick();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0D07;
        tick();
        bus.imem_ack = 1'b0; phase_fetch = 1'b1;
        tick();
        phase_fetch = 1'b0;
        n_cmp++; if ({inst, curr_pc_fd, inst_misaligned} !== {32'h0000_0D07, 32'h100, 1'b1}) begin
            n_fail++; $display("FAIL mis_deliver got inst=%h curr=%h mis=%b", inst, curr_pc_fd, inst_misaligned); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0D08;
        tick();
        bus.imem_ack = 1'b0; phase_fetch = 1'b1;
        tick();
        phase_fetch = 1'b0;
        n_cmp++; if ({curr_pc_fd, next_pc_fd, bus.imem_addr, inst_misaligned} !== {32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL wrap_deliver got curr=%h next=%h addr=%h mis=%b", curr_pc_fd, next_pc_fd, bus.imem_addr, inst_misaligned); end
        tick();
        n_cmp++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL wrap_reissue got req=%b addr=%h", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_reset_midaccess();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.imem_req, stall_fetch, inst_misaligned, inst, curr_pc_fd, next_pc_fd} !== {3'b010, 32'h13, 32'h0, 32'h0}) begin
            n_fail++; $display("FAIL rstmid_async got req=%b stall=%b inst=%h curr=%h", bus.imem_req, stall_fetch, inst, curr_pc_fd); end
        tick();
        rst_n = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD2_BAD2;
        tick();
        bus.imem_ack = 1'b0;
        n_cmp++; if ({bus.imem_req, bus.imem_addr, stall_fetch} !== {1'b1, 32'h0, 1'b1}) begin
            n_fail++; $display("FAIL rstmid_late_ack got req=%b addr=%h stall=%b", bus.imem_req, bus.imem_addr, stall_fetch); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0D09;
        tick();
        bus.imem_ack = 1'b0; phase_fetch = 1'b1;
        tick();
        phase_fetch = 1'b0;
        n_cmp++; if ({inst, curr_pc_fd, next_pc_fd} !== {32'h0000_0D09, 32'h0, 32'h4}) begin
            n_fail++; $display("FAIL rstmid_deliver got %h/%h/%h", inst, curr_pc_fd, next_pc_fd); end
    endtask

    // Model: a stream of words at m_pc; a completed access that saw no redirect since
    // issue makes a word ready; a ready word is consumed by phase_fetch unless redirected.
    task automatic test_random();
        logic [31:0] m_pc = 32'h0, m_inst = 32'h13, m_curr = 32'h0, m_next = 32'h0;
        logic [31:0] inf_addr = 32'h0;
        logic        m_mis = 1'b0, m_mis_pend = 1'b0, m_ready = 1'b0;
        logic        inflight = 1'b0, stale = 1'b0, req_pre, hd0;
        int          dly = 0;
        rst_n = 1'b0; redirect_valid = 1'b0; phase_fetch = 1'b0; bus.imem_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            req_pre = bus.imem_req;
            if (req_pre) begin
                if (!inflight) begin
                    inflight = 1'b1; stale = 1'b0; inf_addr = bus.imem_addr; dly = $urandom_range(0, 3);
                    n_cmp++; if (inf_addr !== m_pc) begin
                        n_fail++; $display("FAIL rnd_issue_addr cyc %0d got %h exp %h", c, inf_addr, m_pc); end
                end else begin
                    n_cmp++; if (bus.imem_addr !== inf_addr) begin
                        n_fail++; $display("FAIL rnd_addr_stable cyc %0d got %h exp %h", c, bus.imem_addr, inf_addr); end
                end
                bus.imem_ack = (dly == 0);
                bus.imem_rdata = (dly == 0) ? mem_word(inf_addr) : $urandom;
                if (dly > 0) dly--;
            end else begin
                bus.imem_ack = ($urandom_range(0, 5) == 0);
                bus.imem_rdata = $urandom;
            end
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom;
            phase_fetch = $urandom_range(0, 1);
            @(posedge clk);
            hd0 = m_ready;
            if (redirect_valid) begin
                m_pc = {redirect_pc[31:2], 2'b00}; m_mis_pend = |redirect_pc[1:0]; m_ready = 1'b0;
            end else if (hd0 && phase_fetch) begin
                m_inst = mem_word(m_pc); m_curr = m_pc; m_next = m_pc + 32'd4; m_mis = m_mis_pend;
                m_pc = m_pc + 32'd4; m_ready = 1'b0;
            end
            if (req_pre && bus.imem_ack) begin
                inflight = 1'b0;
                if (!stale && !redirect_valid) m_ready = 1'b1;
            end else if (req_pre && redirect_valid) begin
                stale = 1'b1;
            end
            #1;
            n_cmp++; if (stall_fetch !== !m_ready) begin
                n_fail++; $display("FAIL rnd_stall cyc %0d got %b exp %b", c, stall_fetch, !m_ready); end
            n_cmp++; if ({inst, curr_pc_fd, next_pc_fd, inst_misaligned} !== {m_inst, m_curr, m_next, m_mis}) begin
                n_fail++; $display("FAIL rnd_outs cyc %0d got %h/%h/%h/%b exp %h/%h/%h/%b", c,
                    inst, curr_pc_fd, next_pc_fd, inst_misaligned, m_inst, m_curr, m_next, m_mis); end
        end
        redirect_valid = 1'b0; phase_fetch = 1'b0; bus.imem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_ack_delay();
        test_redirect_wait();
        test_redirect_hold();
        test_misaligned();
        test_wrap();
        test_reset_midaccess();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the width of the program counter and address.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit, the CPU clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port phase_fetch, input, 1 bit, the output-stage FF enable; it advances the stage only when stall_fetch=0.
REQ-006 The block SHALL have port redirect_valid, input, 1 bit, a one-cycle pulse requesting a PC change for a taken jump or branch.
REQ-007 The block SHALL have port redirect_pc, input, XLEN bits, the redirect target, sampled when redirect_valid=1.
REQ-008 The block SHALL have port imem_req, output, 1 bit, the instruction memory request, registered.
REQ-009 The block SHALL have port imem_addr, output, XLEN bits, the request address, equal to the internal pc.
REQ-010 The block SHALL have port imem_ack, input, 1 bit, the read completion strobe.
REQ-011 The block SHALL have port imem_rdata, input, 32 bits, the read data, valid when imem_ack=1.
REQ-012 The block SHALL have port inst, output, 32 bits, the fetched instruction passed to decode.
REQ-013 The block SHALL have ports curr_pc_fd and next_pc_fd, outputs, XLEN bits each, giving the address of inst and that address+4.
REQ-014 The block SHALL have port inst_misaligned, output, 1 bit, asserted when the last accepted redirect target had bits [1:0] != 0.
REQ-015 The block SHALL have port stall_fetch, output, 1 bit, meaning no instruction is ready (stall_fetch = state != HOLD).

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE -> WAIT on the next edge, with imem_req set to 1.
REQ-017 In WAIT, imem_req and imem_addr SHALL stay stable until imem_ack=1; on ack, imem_rdata is captured into the buffer, imem_req clears and the FSM goes to HOLD.
REQ-018 In HOLD with phase_fetch=1 and no redirect, the block SHALL set inst<=buffer, curr_pc_fd<=pc, next_pc_fd<=pc+4 and pc<=pc+4, then go to IDLE.
REQ-019 Outputs inst, curr_pc_fd, next_pc_fd and inst_misaligned SHALL change only on the HOLD-and-phase_fetch event or on reset.
REQ-020 phase_fetch SHALL be ignored in IDLE and WAIT.
REQ-021 imem_ack SHALL be ignored in IDLE and HOLD.
REQ-022 A redirect_valid pulse in any state SHALL set pc <= {redirect_pc[XLEN-1:2],2'b00} and set the pending inst_misaligned value to |redirect_pc[1:0].
REQ-023 A redirect in IDLE SHALL leave the FSM in IDLE, so the request is issued with the new pc.
REQ-024 A redirect in WAIT SHALL set a flush flag; the outstanding access still completes (imem_req held until ack), its data is discarded, and the FSM goes to IDLE instead of HOLD.
REQ-025 A redirect in WAIT in the same cycle as imem_ack SHALL discard the data and go to IDLE.
REQ-026 A redirect in HOLD SHALL discard the buffer and go to IDLE.
REQ-027 When a redirect and phase_fetch occur together in HOLD, the redirect SHALL win and the decode-facing outputs SHALL be unchanged.
REQ-028 pc+4 SHALL wrap modulo 2^XLEN (e.g. 32'hFFFF_FFFC -> 32'h0000_0000, next_pc_fd=0).
REQ-029 Minimum fetch latency SHALL be 2 cycles (IDLE 1 cycle, WAIT 1 cycle with immediate ack), with stall_fetch low from the third cycle.
REQ-030 Each WAIT cycle without ack SHALL add one cycle of latency.

Reset
REQ-031 On rst_n=0, asynchronously: state=IDLE, pc=RESET_VECTOR, imem_req=0, flush=0, inst=32'h0000_0013 (NOP), curr_pc_fd=0, next_pc_fd=0, inst_misaligned=0, and stall_fetch=1.
REQ-032 Reset asserted mid-access SHALL abandon the access; a late imem_ack after reset release SHALL be ignored (FSM in IDLE).

Verification
REQ-033 Verification SHALL check: reset release, ack on first WAIT cycle, phase_fetch on third cycle -> imem_addr=0, inst=rdata, curr_pc_fd=0, next_pc_fd=4, pc=4.
REQ-034 Verification SHALL check: ack delayed 5 cycles -> imem_req and imem_addr stable for 5 cycles and stall_fetch=1 throughout.
REQ-035 Verification SHALL check: redirect_pc=32'h100 in WAIT, then ack -> data dropped, next request to 32'h100, and decode-facing outputs unchanged.
REQ-036 Verification SHALL check: redirect plus phase_fetch together in HOLD -> outputs unchanged and next imem_addr equals the redirect target.
REQ-037 Verification SHALL check: redirect_pc=32'h102 -> imem_addr=32'h100 and inst_misaligned=1 with the next delivered instruction.
REQ-038 Verification SHALL check: pc=32'hFFFF_FFFC delivered -> next_pc_fd=0 and next imem_addr=0.
